// File: rtl/instr_prefetch_pkg.sv
// ============================================================================
// instr_prefetch_pkg : shared constants for the 6502 instruction prefetcher
// Revision: 1.0
// ============================================================================
`default_nettype none

package instr_prefetch_pkg;

   localparam int          ADDR_W_DEFAULT = 16;
   localparam logic [15:0] RESET_VECTOR   = 16'hFFFC;

   localparam logic [1:0] VEC_LO   = 2'd0;
   localparam logic [1:0] VEC_HI   = 2'd1;
   localparam logic [1:0] VEC_WAIT = 2'd2;
   localparam logic [1:0] RUN      = 2'd3;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// byte_fifo : synchronous FIFO with push/pop/flush and occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a simultaneous pop frees the slot, so a push at full still lands
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/instr_prefetch.sv
// ============================================================================
// instr_prefetch : reset-vector fetch, sequential byte prefetch into a FIFO,
// redirect flush. Option macro INSTR_PREFETCH_BYPASS_EN: same-cycle bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_prefetch
   import instr_prefetch_pkg::*;
#(
   parameter int DEPTH           = 8,
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_W          = ADDR_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      redirect_valid,
   input  logic [ADDR_W-1:0]         redirect_pc,
   output logic                      mem_req,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic                      mem_gnt,
   input  logic                      mem_rvalid,
   input  logic [7:0]                mem_rdata,
   output logic [7:0]                instr,
   output logic [ADDR_W-1:0]         instr_pc,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int              CW        = $clog2(DEPTH) + 1;
   localparam int              FW        = 8 + ADDR_W;
   localparam logic [CW-1:0]   C_DEPTH   = CW'(DEPTH);
   localparam logic [CW-1:0]   C_MAX_OUT = CW'(MAX_OUTSTANDING);

   logic [1:0]        state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [7:0]        pc_lo;
   logic              got_lo;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     drop_cnt;

   logic              grant;
   logic              kept;
   logic              accept;
   logic              vec_byte;
   logic              room;
   logic              bypass;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic [FW-1:0]     fifo_dout;
   logic [CW:0]       fill_sum;

   assign grant    = mem_req & mem_gnt;
   assign kept     = mem_rvalid & (drop_cnt == '0) & ~redirect_valid;
   assign accept   = kept & (state == RUN);
   assign vec_byte = kept & (state != RUN);
   assign fill_sum = {1'b0, occupancy} + {1'b0, outstanding};
   assign room     = (fill_sum < {1'b0, C_DEPTH});

   always_comb begin
      mem_req  = 1'b0;
      mem_addr = fetch_pc;
      case (state)
         VEC_LO: begin
            mem_req  = 1'b1;
            mem_addr = ADDR_W'(RESET_VECTOR);
         end
         VEC_HI: begin
            mem_req  = 1'b1;
            mem_addr = ADDR_W'(RESET_VECTOR + 16'd1);
         end
         RUN: mem_req = room & (outstanding < C_MAX_OUT);
         default: mem_req = 1'b0;
      endcase
      // held low while reset is asserted and during a redirect cycle
      mem_req = mem_req & ~redirect_valid & rst;
   end

`ifdef INSTR_PREFETCH_BYPASS_EN
   assign bypass = accept & fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_push   = accept & ~(bypass & instr_ready);
   assign fifo_pop    = instr_ready & ~redirect_valid;
   assign instr_valid = ~fifo_empty | bypass;
   assign instr       = ~fifo_empty ? fifo_dout[7:0]    : (bypass ? mem_rdata : 8'h00);
   assign instr_pc    = ~fifo_empty ? fifo_dout[FW-1:8] : (bypass ? resp_pc : '0);

   byte_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   ({resp_pc, mem_rdata}),
      .pop   (fifo_pop),
      .flush (redirect_valid),
      .dout  (fifo_dout),
      .count (occupancy),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= VEC_LO;
         fetch_pc    <= '0;
         resp_pc     <= '0;
         pc_lo       <= '0;
         got_lo      <= 1'b0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid);
         if (redirect_valid) begin
            state    <= RUN;
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            got_lo   <= 1'b0;
            // every read still in flight after this cycle belongs to the old stream
            drop_cnt <= (mem_rvalid && outstanding != '0) ? outstanding - 1'b1 : outstanding;
         end else begin
            if (mem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            if (accept) resp_pc <= resp_pc + 1'b1;
            case (state)
               VEC_LO:  if (grant) state <= VEC_HI;
               VEC_HI:  if (grant) state <= VEC_WAIT;
               RUN:     if (grant) fetch_pc <= fetch_pc + 1'b1;
               default: ;
            endcase
            if (vec_byte) begin
               if (!got_lo) begin
                  pc_lo  <= mem_rdata;
                  got_lo <= 1'b1;
               end else begin
                  state    <= RUN;
                  fetch_pc <= ADDR_W'({mem_rdata, pc_lo});
                  resp_pc  <= ADDR_W'({mem_rdata, pc_lo});
                  got_lo   <= 1'b0;
               end
            end
         end
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(fifo_push && fifo_full && !fifo_pop));
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch.sv
// ============================================================================
// tb_instr_prefetch : randomized scoreboard bench for instr_prefetch
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_prefetch;

   localparam int DEPTH   = 8;
   localparam int MAX_OUT = 2;
`ifdef INSTR_PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int M_VLO = 0, M_VHI = 1, M_VWAIT = 2, M_RUN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [7:0]  mem_rdata = '0;
   logic [7:0]  instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [3:0]  occupancy;

   instr_prefetch dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_gnt        (mem_gnt),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] daddr;
      logic [15:0] maddr;
      int          epoch;
      bit          vec;
      longint      rdy;
   } req_t;

   typedef struct {
      logic [15:0] pc;
      logic [7:0]  b;
   } exp_t;

   req_t        pend_q[$];
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          epoch = 0;
   int          mstate = M_VLO;
   int          vec_got = 0;
   logic [7:0]  vec_lo = '0;
   logic [15:0] next_fetch = '0;
   longint      cyc = 0;
   longint      last_rdy = 0;
   int          gnt_pct = 100;
   int          rdy_pct = 100;
   int          lat_fixed = 1;
   int          grant_cnt = 0;
   int          consumed = 0;
   bit          resp_live_now = 1'b0;
   int          mon_fb;
   exp_t        mon_e;

   // memory image: reset vector points at 0xC000, everything else is a hash of the address
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      logic [7:0] v;
      if (a == 16'hFFFC)      v = 8'h00;
      else if (a == 16'hFFFD) v = 8'hC0;
      else                    v = a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5A;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit redir, input logic [15:0] rpc);
      req_t r;
      int   lat;
      @(posedge clk);
      #1;
      cyc++;
      if (redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = rpc;
         epoch++;
         exp_q.delete();
         mstate     = M_RUN;
         next_fetch = rpc;
      end else begin
         redirect_valid = 1'b0;
      end
      instr_ready   = ($urandom_range(0, 99) < rdy_pct);
      mem_gnt       = ($urandom_range(0, 99) < gnt_pct);
      resp_live_now = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      if (pend_q.size() > 0 && pend_q[0].rdy <= cyc) begin
         r          = pend_q.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = mem_byte(r.daddr);
         if (r.epoch == epoch) begin
            if (r.vec) begin
               if (vec_got == 0) begin
                  vec_lo  = mem_byte(r.maddr);
                  vec_got = 1;
               end else begin
                  mstate     = M_RUN;
                  next_fetch = {mem_byte(r.maddr), vec_lo};
               end
            end else begin
               exp_q.push_back('{r.maddr, mem_byte(r.maddr)});
               resp_live_now = 1'b1;
            end
         end
      end
      @(negedge clk);
      if (rst && mem_req && mem_gnt) begin
         grant_cnt++;
         r.daddr = mem_addr;
         r.epoch = epoch;
         r.vec   = 1'b0;
         case (mstate)
            M_VLO: begin r.maddr = 16'hFFFC; r.vec = 1'b1; mstate = M_VHI; end
            M_VHI: begin r.maddr = 16'hFFFD; r.vec = 1'b1; mstate = M_VWAIT; end
            M_VWAIT: begin
               check("no_req_in_vec_wait", {31'd0, mem_req}, 32'd0);
               r.maddr = mem_addr;
               r.epoch = -1;
            end
            default: begin r.maddr = next_fetch; next_fetch = next_fetch + 16'd1; end
         endcase
         if (mstate != M_VWAIT || r.vec) check("mem_addr", {16'd0, mem_addr}, {16'd0, r.maddr});
         lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
         r.rdy = (cyc + lat > last_rdy) ? cyc + lat : last_rdy + 1;
         last_rdy = r.rdy;
         pend_q.push_back(r);
         check("outstanding_limit", {31'd0, pend_q.size() <= MAX_OUT}, 32'd1);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_occupancy", {28'd0, occupancy}, 32'd0);
      check("rst_instr", {24'd0, instr}, 32'd0);
      check("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
      redirect_valid = 1'b0;
      mem_rvalid     = 1'b0;
      mem_gnt        = 1'b0;
      instr_ready    = 1'b0;
      resp_live_now  = 1'b0;
      pend_q.delete();
      exp_q.delete();
      epoch++;
      mstate   = M_VLO;
      vec_got  = 0;
      last_rdy = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst && !redirect_valid) begin
         mon_fb = exp_q.size() - (resp_live_now ? 1 : 0);
         check("occupancy", {28'd0, occupancy}, mon_fb);
         check("instr_valid", {31'd0, instr_valid}, {31'd0, (mon_fb > 0) || (BYP && resp_live_now)});
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte_pc", {16'd0, instr_pc}, 32'hFFFFFFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("instr_pc", {16'd0, instr_pc}, {16'd0, mon_e.pc});
               check("instr_byte", {24'd0, instr}, {24'd0, mon_e.b});
               consumed++;
            end
         end
      end
   end

   initial begin
      int w;
      int n;
      logic [15:0] rp;

      // reset vector fetch then straight-line delivery from 0xC000
      do_reset();
      gnt_pct = 100; rdy_pct = 100; lat_fixed = 1;
      repeat (60) cycle(1'b0, 16'h0);

      // back-pressure: buffer fills to DEPTH, then one pop triggers one refill
      rdy_pct = 0; lat_fixed = 2;
      repeat (40) cycle(1'b0, 16'h0);
      grant_cnt = 0;
      repeat (5) cycle(1'b0, 16'h0);
      check("no_req_when_full", grant_cnt, 32'd0);
      check("occupancy_full", {28'd0, occupancy}, DEPTH);
      check("none_outstanding_when_full", pend_q.size(), 32'd0);
      grant_cnt = 0;
      rdy_pct = 100;
      cycle(1'b0, 16'h0);
      rdy_pct = 0;
      repeat (10) cycle(1'b0, 16'h0);
      check("one_refill_request", grant_cnt, 32'd1);
      check("occupancy_refilled", {28'd0, occupancy}, DEPTH);

      // redirect with two reads in flight
      rdy_pct = 100; lat_fixed = 3;
      w = 0;
      while (pend_q.size() < 2 && w < 50) begin
         cycle(1'b0, 16'h0);
         w++;
      end
      check("two_outstanding_before_redirect", pend_q.size(), 32'd2);
      cycle(1'b1, 16'h1234);
      repeat (30) cycle(1'b0, 16'h0);

      // redirect while the high vector byte is being requested
      do_reset();
      gnt_pct = 100; rdy_pct = 100; lat_fixed = 1;
      cycle(1'b0, 16'h0);
      cycle(1'b1, 16'h0400);
      n = consumed;
      repeat (30) cycle(1'b0, 16'h0);
      check("delivery_after_vec_redirect", {31'd0, consumed > n}, 32'd1);

      // randomized traffic with random redirects, then again from a fresh reset
      gnt_pct = 70; rdy_pct = 60; lat_fixed = 0;
      for (int i = 0; i < 2000; i++) begin
         rp = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
         cycle($urandom_range(0, 99) < 3, rp);
      end
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         rp = 16'($urandom);
         cycle($urandom_range(0, 99) < 3, rp);
      end
      rdy_pct = 100; gnt_pct = 100;
      repeat (50) cycle(1'b0, 16'h0);
      check("bytes_delivered_min", {31'd0, consumed >= 500}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
